// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, keeps at most one imem request in flight
// and buffers {pc, instr} for decode. Optional feature macro: FETCH_ALIGN_CHECK_EN.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_word,
  output logic [31:0] inst_pcplus4
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_misalign
`endif
);

  localparam int             PTR_W    = $clog2(BUF_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(BUF_DEPTH);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [31:0]      fetch_pc;
  logic [31:0]      req_pc;
  logic [31:0]      load_pc;
  logic [31:0]      pc_mem   [BUF_DEPTH];
  logic [31:0]      word_mem [BUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             issue_block;
  logic             granted;
  logic             push;
  logic             pop;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign;

  assign load_pc        = redirect_pc;
  assign issue_block    = misalign;
  assign fetch_misalign = misalign;

  // Sticky until the next redirect; an aligned target clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign <= 1'b0;
    end else if (redirect) begin
      misalign <= |redirect_pc[1:0];
    end
  end
`else
  assign load_pc     = redirect_pc & 32'hFFFF_FFFC;
  assign issue_block = 1'b0;
`endif

  assign full       = (count == FULL_CNT);
  assign inst_valid = (count != '0);

  // Only S_REQ has nothing in flight, so the count alone bounds issue here.
  assign imem_req  = !rst && (state == S_REQ) && !full && !issue_block;
  assign imem_addr = fetch_pc;
  assign granted   = imem_req && imem_gnt;

  // Redirect squashes any same-cycle push or pop.
  assign push = !redirect && (state == S_WAIT) && imem_rvalid;
  assign pop  = !redirect && inst_valid && inst_ready;

  assign inst_pc      = inst_valid ? pc_mem[rd_ptr]   : '0;
  assign inst_word    = inst_valid ? word_mem[rd_ptr] : '0;
  assign inst_pcplus4 = inst_pc + 32'd4;

  // NOTE: every output of a combinational block gets a default first so that
  // no path through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_REQ: begin
        if (granted) begin
          state_nxt = redirect ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_nxt = S_REQ;
        end else if (redirect) begin
          state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rvalid) begin
          state_nxt = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase
  end

  // NOTE: registers are written with non-blocking assignments so that every
  // read in this block sees the pre-edge value regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_REQ;
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      state <= state_nxt;
      if (granted) begin
        req_pc <= fetch_pc;
      end
      if (redirect) begin
        fetch_pc <= load_pc;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (granted) begin
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end
    end
  end

  // NOTE: buffer storage has no reset; entries are only visible through
  // count, which is reset, and the outputs are masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= req_pc;
      word_mem[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: queue-based reference model compared
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_inst_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_pc;
  logic [31:0] inst_word;
  logic [31:0] inst_pcplus4;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  always #5 clk = ~clk;

  inst_fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_pc(inst_pc), .inst_word(inst_word), .inst_pcplus4(inst_pcplus4)
`ifdef FETCH_ALIGN_CHECK_EN
    , .fetch_misalign(fetch_misalign)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the buffer is a queue; "outstanding" means one request
  // granted and not yet answered, "live" means its answer is still wanted.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  entry_t      m_q[$];
  logic [31:0] m_fetch_pc;
  logic [31:0] m_out_pc;
  bit          m_out;
  bit          m_live;
  bit          m_mis;

  function automatic bit m_req();
    return !m_out && (m_q.size() < DEPTH) && !m_mis;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_fetch_pc = RESET_PC;
      m_out      = 1'b0;
      m_live     = 1'b0;
      m_mis      = 1'b0;
    end else begin
      bit     grant;
      entry_t e;
      grant = m_req() && imem_gnt;
      if (redirect) begin
        m_q.delete();
`ifdef FETCH_ALIGN_CHECK_EN
        m_fetch_pc = redirect_pc;
        m_mis      = (redirect_pc[1:0] != 2'b00);
`else
        m_fetch_pc = {redirect_pc[31:2], 2'b00};
`endif
        if (m_out) begin
          if (imem_rvalid) m_out = 1'b0;
          else             m_live = 1'b0;
        end else if (grant) begin
          m_out  = 1'b1;
          m_live = 1'b0;
        end
      end else begin
        if (m_q.size() > 0 && inst_ready) void'(m_q.pop_front());
        if (m_out && imem_rvalid) begin
          if (m_live) begin
            e.pc   = m_out_pc;
            e.word = imem_rdata;
            m_q.push_back(e);
          end
          m_out = 1'b0;
        end else if (grant) begin
          m_out      = 1'b1;
          m_live     = 1'b1;
          m_out_pc   = m_fetch_pc;
          m_fetch_pc = m_fetch_pc + 32'd4;
        end
      end
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      if (rst) begin
        check("rst_imem_req", imem_req, 0);
        check("rst_inst_valid", inst_valid, 0);
        check("rst_inst_pc", inst_pc, 0);
        check("rst_inst_word", inst_word, 0);
      end else begin
        check("imem_req", imem_req, m_req());
        if (m_req()) check("imem_addr", imem_addr, m_fetch_pc);
        check("inst_valid", inst_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
          check("inst_pc", inst_pc, m_q[0].pc);
          check("inst_word", inst_word, m_q[0].word);
          check("inst_pcplus4", inst_pcplus4, m_q[0].pc + 32'd4);
        end
`ifdef FETCH_ALIGN_CHECK_EN
        check("fetch_misalign", fetch_misalign, m_mis);
`endif
      end
    end
  end

  // Step to just after the falling edge: outputs are settled, inputs may change.
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  // The imem side answers only while the model holds an outstanding request.
  task automatic drive(input bit rd, input logic [31:0] rpc, input bit g,
                       input bit rv, input bit rdy);
    redirect    = rd;
    redirect_pc = rpc;
    imem_gnt    = g;
    imem_rvalid = rv && m_out;
    imem_rdata  = $urandom;
    inst_ready  = rdy;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 32'h0, 0, 0, 0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  // Stream with full handshaking until n instructions are seen or budget expires.
  task automatic stream(input int n, input string tag, input logic [31:0] first_pc);
    int got;
    got = 0;
    for (int c = 0; c < 20 * n && got < n; c++) begin
      drive(0, 32'h0, 1, 1, 1);
      next_cycle();
      if (inst_valid) begin
        check({tag, "_pc"}, inst_pc, first_pc + 32'(4 * got));
        check({tag, "_pcplus4"}, inst_pcplus4, first_pc + 32'(4 * got + 4));
        got++;
      end
    end
    check({tag, "_count"}, got, n);
  endtask

  task automatic wait_valid(input string tag);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      drive(0, 32'h0, 1, 1, 0);
      next_cycle();
      seen = inst_valid;
    end
    check({tag, "_valid_seen"}, seen, 1);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 32'h0, 0, 0, 0);
    cmp_en = 1'b1;

    // T1: reset, then a reset pulse while a response is awaited
    next_cycle();
    check("t1_req_in_rst", imem_req, 0);
    check("t1_valid_in_rst", inst_valid, 0);
    rst = 1'b0;
    drive(0, 32'h0, 1, 0, 0);
    next_cycle();
    check("t1_req_in_wait", imem_req, 0);
    rst = 1'b1;
    drive(0, 32'h0, 0, 0, 0);
    next_cycle();
    check("t1_req_rst_pulse", imem_req, 0);
    check("t1_valid_rst_pulse", inst_valid, 0);
    rst = 1'b0;
    next_cycle();
    check("t1_req_after", imem_req, 1);
    check("t1_addr_after", imem_addr, RESET_PC);

    // T2: zero-wait streaming gives 0,4,8,C
    do_reset();
    stream(4, "t2", 32'h0);

    // T3: backpressure fills exactly DEPTH entries, one pop reopens issue
    do_reset();
    for (int c = 0; c < 12; c++) begin
      drive(0, 32'h0, 1, 1, 0);
      next_cycle();
    end
    check("t3_req_full", imem_req, 0);
    check("t3_valid_full", inst_valid, 1);
    check("t3_head_pc", inst_pc, 32'h0);
    check("t3_pc_hold", imem_addr, 32'h8);
    drive(0, 32'h0, 0, 0, 1);
    next_cycle();
    check("t3_req_after_pop", imem_req, 1);
    check("t3_addr_after_pop", imem_addr, 32'h8);
    check("t3_head_after_pop", inst_pc, 32'h4);

    // T4: redirect while waiting drops the stale word
    do_reset();
    drive(0, 32'h0, 1, 0, 0);
    next_cycle();
    drive(1, 32'h0000_0100, 0, 0, 0);
    next_cycle();
    check("t4_req_drop", imem_req, 0);
    drive(0, 32'h0, 0, 1, 0);
    next_cycle();
    check("t4_req_new", imem_req, 1);
    check("t4_addr_new", imem_addr, 32'h100);
    check("t4_no_stale", inst_valid, 0);
    wait_valid("t4");
    check("t4_pc", inst_pc, 32'h100);

    // T5: redirect on the grant cycle with a pop pending
    do_reset();
    wait_valid("t5_fill");
    check("t5_req_pre", imem_req, 1);
    check("t5_addr_pre", imem_addr, 32'h4);
    drive(1, 32'h0000_0300, 1, 1, 1);
    next_cycle();
    check("t5_flushed", inst_valid, 0);
    check("t5_req_drop", imem_req, 0);
    drive(0, 32'h0, 0, 1, 0);
    next_cycle();
    check("t5_req_new", imem_req, 1);
    check("t5_addr_new", imem_addr, 32'h300);
    wait_valid("t5");
    check("t5_pc", inst_pc, 32'h300);

    // T6: unaligned redirect target
    do_reset();
    drive(1, 32'h0000_0102, 0, 0, 0);
    next_cycle();
`ifdef FETCH_ALIGN_CHECK_EN
    check("t6_misalign_set", fetch_misalign, 1);
    for (int c = 0; c < 4; c++) begin
      drive(0, 32'h0, 1, 1, 1);
      next_cycle();
      check("t6_req_blocked", imem_req, 0);
    end
    check("t6_misalign_sticky", fetch_misalign, 1);
    drive(1, 32'h0000_0200, 0, 0, 0);
    next_cycle();
    check("t6_misalign_clr", fetch_misalign, 0);
    check("t6_req_new", imem_req, 1);
    check("t6_addr_new", imem_addr, 32'h200);
`else
    check("t6_req_forced", imem_req, 1);
    check("t6_addr_forced", imem_addr, 32'h100);
`endif

    // PC wrap across the top of the address space
    do_reset();
    drive(1, 32'hFFFF_FFF8, 0, 0, 0);
    next_cycle();
    stream(3, "wrap", 32'hFFFF_FFF8);

    // Random traffic against the model
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      logic [31:0] rpc;
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
        drive(0, 32'h0, 0, 0, 0);
        next_cycle();
        rst = 1'b0;
      end
      rpc = $urandom;
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
`ifdef FETCH_ALIGN_CHECK_EN
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
`endif
      drive($urandom_range(0, 11) == 0, rpc, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0);
      next_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
